// File: rtl/ixc_assign_pipe.sv
// Elastic register pipeline that carries a WIDTH-bit word from R to L through STAGES
// valid/ready stages, with bubble collapsing, synchronous flush and an occupancy count.
module ixc_assign_pipe #(
    parameter int WIDTH      = 73,
    parameter int STAGES     = 2,
    parameter bit RESET_DATA = 1'b0,
    localparam int OCC_W     = (STAGES < 1) ? 1 : $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [WIDTH-1:0] R,
    output logic             l_valid,
    input  logic             l_ready,
    output logic [WIDTH-1:0] L,
    output logic [OCC_W-1:0] occupancy
);

    if (STAGES == 0) begin : g_pass
        assign L         = R;
        assign l_valid   = r_valid & ~flush;
        assign r_ready   = l_ready & ~flush;
        assign occupancy = '0;
    end else begin : g_pipe
        logic [STAGES:1]  valid_q;
        logic [STAGES:1]  valid_d;
        logic [STAGES:1]  rdy;
        logic [STAGES:1]  in_v;
        logic [WIDTH-1:0] data_q [1:STAGES];
        logic [WIDTH-1:0] data_d [1:STAGES];
        logic [WIDTH-1:0] in_d   [1:STAGES];

        // An empty stage always accepts, so words compact toward L under back-pressure.
        always_comb begin
            rdy[STAGES] = l_ready | ~valid_q[STAGES];
            for (int i = STAGES - 1; i >= 1; i--) begin
                rdy[i] = rdy[i+1] | ~valid_q[i];
            end
        end

        always_comb begin
            in_v[1] = r_valid & ~flush;
            in_d[1] = R;
            for (int i = 2; i <= STAGES; i++) begin
                in_v[i] = valid_q[i-1];
                in_d[i] = data_q[i-1];
            end
        end

        // Data only moves with a valid word and never during flush, so bubbles keep old data.
        always_comb begin
            for (int i = 1; i <= STAGES; i++) begin
                valid_d[i] = valid_q[i];
                data_d[i]  = data_q[i];
                if (flush) begin
                    valid_d[i] = 1'b0;
                end else if (rdy[i]) begin
                    valid_d[i] = in_v[i];
                    if (in_v[i]) begin
                        data_d[i] = in_d[i];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= '0;
            end else begin
                valid_q <= valid_d;
            end
        end

        if (RESET_DATA) begin : g_rst_data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 1; i <= STAGES; i++) data_q[i] <= '0;
                end else begin
                    for (int i = 1; i <= STAGES; i++) data_q[i] <= data_d[i];
                end
            end
        end else begin : g_keep_data
            always_ff @(posedge clk) begin
                for (int i = 1; i <= STAGES; i++) data_q[i] <= data_d[i];
            end
        end

        always_comb begin
            occupancy = '0;
            for (int i = 1; i <= STAGES; i++) begin
                occupancy = occupancy + OCC_W'(valid_q[i]);
            end
        end

        assign r_ready = rdy[1] & ~flush;
        assign l_valid = valid_q[STAGES];
        assign L       = data_q[STAGES];
    end

`ifndef SYNTHESIS
    // Handshake stability on both sides; flush and reset legitimately withdraw words.
    a_r_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_valid && !r_ready && !flush) |=> (r_valid && $stable(R)));
    a_l_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (l_valid && !l_ready && !flush) |=> (flush || (l_valid && $stable(L))));
`endif

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Directed bench for ixc_assign_pipe: several parameterisations side by side, one task per scenario.
module tb_ixc_assign_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // A: WIDTH=73 STAGES=2
    logic a_flush = 0, a_rv = 0, a_rr, a_lv, a_lr = 0;
    logic [72:0] a_R = '0, a_L;
    logic [1:0]  a_occ;
    // B: WIDTH=16 STAGES=3
    logic b_flush = 0, b_rv = 0, b_rr, b_lv, b_lr = 0;
    logic [15:0] b_R = '0, b_L;
    logic [1:0]  b_occ;
    // C: WIDTH=16 STAGES=4 RESET_DATA=1
    logic c_flush = 0, c_rv = 0, c_rr, c_lv, c_lr = 0;
    logic [15:0] c_R = '0, c_L;
    logic [2:0]  c_occ;
    // D/E: pass-through at both width extremes
    logic d_flush = 0, d_rv = 0, d_rr, d_lv, d_lr = 0;
    logic [0:0]  d_R = '0, d_L;
    logic [0:0]  d_occ;
    logic e_flush = 0, e_rv = 0, e_rr, e_lv, e_lr = 0;
    logic [1023:0] e_R = '0, e_L;
    logic [0:0]  e_occ;

    ixc_assign_pipe #(.WIDTH(73), .STAGES(2), .RESET_DATA(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .r_valid(a_rv), .r_ready(a_rr), .R(a_R),
        .l_valid(a_lv), .l_ready(a_lr), .L(a_L), .occupancy(a_occ));
    ixc_assign_pipe #(.WIDTH(16), .STAGES(3), .RESET_DATA(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .r_valid(b_rv), .r_ready(b_rr), .R(b_R),
        .l_valid(b_lv), .l_ready(b_lr), .L(b_L), .occupancy(b_occ));
    ixc_assign_pipe #(.WIDTH(16), .STAGES(4), .RESET_DATA(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .r_valid(c_rv), .r_ready(c_rr), .R(c_R),
        .l_valid(c_lv), .l_ready(c_lr), .L(c_L), .occupancy(c_occ));
    ixc_assign_pipe #(.WIDTH(1), .STAGES(0), .RESET_DATA(1'b0)) u_d (
        .clk(clk), .rst_n(rst_n), .flush(d_flush), .r_valid(d_rv), .r_ready(d_rr), .R(d_R),
        .l_valid(d_lv), .l_ready(d_lr), .L(d_L), .occupancy(d_occ));
    ixc_assign_pipe #(.WIDTH(1024), .STAGES(0), .RESET_DATA(1'b0)) u_e (
        .clk(clk), .rst_n(rst_n), .flush(e_flush), .r_valid(e_rv), .r_ready(e_rr), .R(e_R),
        .l_valid(e_lv), .l_ready(e_lr), .L(e_L), .occupancy(e_occ));

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        tests++; if (a_lv !== 1'b0) begin fails++; $display("FAIL reset_a_lvalid got %b exp 0", a_lv); end
        tests++; if (a_occ !== 2'd0) begin fails++; $display("FAIL reset_a_occ got %0d exp 0", a_occ); end
        tests++; if (a_rr !== 1'b1) begin fails++; $display("FAIL reset_a_rready got %b exp 1", a_rr); end
        tests++; if (b_lv !== 1'b0 || b_occ !== 2'd0) begin fails++; $display("FAIL reset_b got lv=%b occ=%0d exp 0/0", b_lv, b_occ); end
        tests++; if (c_L !== 16'd0) begin fails++; $display("FAIL reset_c_L got %h exp 0", c_L); end
        tests++; if (c_lv !== 1'b0 || c_occ !== 3'd0) begin fails++; $display("FAIL reset_c got lv=%b occ=%0d exp 0/0", c_lv, c_occ); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int t_rv [7]  = '{1, 1, 1, 1, 0, 0, 0};
        int t_lv [7]  = '{0, 0, 1, 1, 1, 1, 0};
        int t_L  [7]  = '{-1, -1, 1, 2, 3, 4, -1};
        int t_occ[7]  = '{0, 1, 2, 2, 2, 1, 0};
        for (int i = 0; i < 7; i++) begin
            a_flush = 1'b0; a_lr = 1'b1; a_rv = t_rv[i][0]; a_R = 73'(i + 1);
            @(negedge clk);
            tests++; if (a_rr !== 1'b1) begin fails++; $display("FAIL stream_rready[%0d] got %b exp 1", i, a_rr); end
            tests++; if (a_lv !== 1'(t_lv[i])) begin fails++; $display("FAIL stream_lvalid[%0d] got %b exp %0d", i, a_lv, t_lv[i]); end
            if (t_L[i] >= 0) begin
                tests++; if (a_L !== 73'(t_L[i])) begin fails++; $display("FAIL stream_L[%0d] got %0d exp %0d", i, a_L, t_L[i]); end
            end
            tests++; if (a_occ !== 2'(t_occ[i])) begin fails++; $display("FAIL stream_occ[%0d] got %0d exp %0d", i, a_occ, t_occ[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fill_drain();
        int t_rv [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        int t_R  [11] = '{1, 2, 3, 4, 4, 4, 5, 0, 0, 0, 0};
        int t_lr [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        int t_rr [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        int t_lv [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        int t_L  [11] = '{-1, -1, -1, 1, 1, 1, 2, 3, 4, 5, -1};
        int t_occ[11] = '{0, 1, 2, 3, 3, 3, 3, 3, 2, 1, 0};
        for (int i = 0; i < 11; i++) begin
            b_flush = 1'b0; b_rv = t_rv[i][0]; b_R = 16'(t_R[i]); b_lr = t_lr[i][0];
            @(negedge clk);
            tests++; if (b_rr !== 1'(t_rr[i])) begin fails++; $display("FAIL fill_rready[%0d] got %b exp %0d", i, b_rr, t_rr[i]); end
            tests++; if (b_lv !== 1'(t_lv[i])) begin fails++; $display("FAIL fill_lvalid[%0d] got %b exp %0d", i, b_lv, t_lv[i]); end
            if (t_L[i] >= 0) begin
                tests++; if (b_L !== 16'(t_L[i])) begin fails++; $display("FAIL fill_L[%0d] got %0d exp %0d", i, b_L, t_L[i]); end
            end
            tests++; if (b_occ !== 2'(t_occ[i])) begin fails++; $display("FAIL fill_occ[%0d] got %0d exp %0d", i, b_occ, t_occ[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bubbles();
        int t_rv [12] = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0};
        int t_R  [12] = '{11, 0, 12, 0, 13, 0, 14, 14, 0, 0, 0, 0};
        int t_lr [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        int t_rr [12] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        int t_lv [12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int t_L  [12] = '{-1, -1, -1, 11, 11, 11, 11, 11, 12, 13, 14, -1};
        int t_occ[12] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 2, 1, 0};
        for (int i = 0; i < 12; i++) begin
            b_flush = 1'b0; b_rv = t_rv[i][0]; b_R = 16'(t_R[i]); b_lr = t_lr[i][0];
            @(negedge clk);
            tests++; if (b_rr !== 1'(t_rr[i])) begin fails++; $display("FAIL bubble_rready[%0d] got %b exp %0d", i, b_rr, t_rr[i]); end
            tests++; if (b_lv !== 1'(t_lv[i])) begin fails++; $display("FAIL bubble_lvalid[%0d] got %b exp %0d", i, b_lv, t_lv[i]); end
            if (t_L[i] >= 0) begin
                tests++; if (b_L !== 16'(t_L[i])) begin fails++; $display("FAIL bubble_L[%0d] got %0d exp %0d", i, b_L, t_L[i]); end
            end
            tests++; if (b_occ !== 2'(t_occ[i])) begin fails++; $display("FAIL bubble_occ[%0d] got %0d exp %0d", i, b_occ, t_occ[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        int t_fl [7]  = '{0, 0, 1, 0, 0, 0, 0};
        int t_rv [7]  = '{1, 1, 1, 1, 0, 0, 0};
        int t_R  [7]  = '{21, 22, 23, 24, 0, 0, 0};
        int t_lr [7]  = '{0, 0, 0, 1, 1, 1, 1};
        int t_rr [7]  = '{1, 1, 0, 1, 1, 1, 1};
        int t_lv [7]  = '{0, 0, 1, 0, 0, 1, 0};
        int t_L  [7]  = '{-1, -1, 21, 21, 21, 24, 24};
        int t_occ[7]  = '{0, 1, 2, 0, 1, 1, 0};
        for (int i = 0; i < 7; i++) begin
            a_flush = t_fl[i][0]; a_rv = t_rv[i][0]; a_R = 73'(t_R[i]); a_lr = t_lr[i][0];
            @(negedge clk);
            tests++; if (a_rr !== 1'(t_rr[i])) begin fails++; $display("FAIL flush_rready[%0d] got %b exp %0d", i, a_rr, t_rr[i]); end
            tests++; if (a_lv !== 1'(t_lv[i])) begin fails++; $display("FAIL flush_lvalid[%0d] got %b exp %0d", i, a_lv, t_lv[i]); end
            if (t_L[i] >= 0) begin
                tests++; if (a_L !== 73'(t_L[i])) begin fails++; $display("FAIL flush_L[%0d] got %0d exp %0d", i, a_L, t_L[i]); end
            end
            tests++; if (a_occ !== 2'(t_occ[i])) begin fails++; $display("FAIL flush_occ[%0d] got %0d exp %0d", i, a_occ, t_occ[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        int p_lv [5]  = '{0, 0, 0, 0, 1};
        int p_L  [5]  = '{0, 0, 0, 0, 31};
        int p_occ[5]  = '{0, 1, 2, 3, 4};
        int q_lv [6]  = '{0, 0, 0, 0, 1, 0};
        int q_L  [6]  = '{0, 0, 0, 0, 41, 41};
        int q_occ[6]  = '{0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            c_flush = 1'b0; c_lr = 1'b1; c_rv = 1'b1; c_R = 16'(31 + i);
            @(negedge clk);
            tests++; if (c_lv !== 1'(p_lv[i]) || c_L !== 16'(p_L[i])) begin fails++; $display("FAIL arst_pre[%0d] got lv=%b L=%0d exp %0d/%0d", i, c_lv, c_L, p_lv[i], p_L[i]); end
            tests++; if (c_occ !== 3'(p_occ[i])) begin fails++; $display("FAIL arst_pre_occ[%0d] got %0d exp %0d", i, c_occ, p_occ[i]); end
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (c_lv !== 1'b0) begin fails++; $display("FAIL arst_lvalid got %b exp 0", c_lv); end
        tests++; if (c_occ !== 3'd0) begin fails++; $display("FAIL arst_occ got %0d exp 0", c_occ); end
        tests++; if (c_L !== 16'd0) begin fails++; $display("FAIL arst_L got %0d exp 0", c_L); end
        tests++; if (c_rr !== 1'b1) begin fails++; $display("FAIL arst_rready got %b exp 1", c_rr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c_rv = (i == 0); c_R = (i == 0) ? 16'd41 : 16'd0;
            @(negedge clk);
            tests++; if (c_lv !== 1'(q_lv[i]) || c_L !== 16'(q_L[i])) begin fails++; $display("FAIL arst_post[%0d] got lv=%b L=%0d exp %0d/%0d", i, c_lv, c_L, q_lv[i], q_L[i]); end
            tests++; if (c_occ !== 3'(q_occ[i])) begin fails++; $display("FAIL arst_post_occ[%0d] got %0d exp %0d", i, c_occ, q_occ[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_passthrough();
        logic hold_d, hold_e;
        for (int i = 0; i < 40; i++) begin
            hold_d = d_rv && !(d_lr && !d_flush);
            hold_e = e_rv && !(e_lr && !e_flush);
            if (!hold_d) begin
                d_rv = 1'($urandom_range(0, 1));
                d_R  = 1'($urandom_range(0, 1));
            end
            if (!hold_e) begin
                e_rv = 1'($urandom_range(0, 1));
                for (int k = 0; k < 32; k++) e_R[k*32 +: 32] = $urandom();
            end
            d_lr = 1'($urandom_range(0, 1));
            e_lr = 1'($urandom_range(0, 1));
            d_flush = ($urandom_range(0, 7) == 0);
            e_flush = ($urandom_range(0, 7) == 0);
            #2;
            tests++; if (d_L !== d_R) begin fails++; $display("FAIL pass1_L[%0d] got %b exp %b", i, d_L, d_R); end
            tests++; if (d_lv !== (d_rv & ~d_flush) || d_rr !== (d_lr & ~d_flush) || d_occ !== 1'b0) begin
                fails++; $display("FAIL pass1_ctl[%0d] got lv=%b rr=%b occ=%0d exp %b/%b/0", i, d_lv, d_rr, d_occ, d_rv & ~d_flush, d_lr & ~d_flush);
            end
            tests++; if (e_L !== e_R) begin fails++; $display("FAIL pass1024_L[%0d] low bits got %h exp %h", i, e_L[63:0], e_R[63:0]); end
            tests++; if (e_lv !== (e_rv & ~e_flush) || e_rr !== (e_lr & ~e_flush) || e_occ !== 1'b0) begin
                fails++; $display("FAIL pass1024_ctl[%0d] got lv=%b rr=%b occ=%0d exp %b/%b/0", i, e_lv, e_rr, e_occ, e_rv & ~e_flush, e_lr & ~e_flush);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_fill_drain();
        test_bubbles();
        test_flush();
        test_async_reset();
        test_passthrough();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
